// File: rtl/countdown_timer_pkg.sv
// Shared types and BCD helpers for the two-digit countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam int         BCD_WIDTH     = 8;

  // Clamp each BCD digit to 9 so an illegal nibble can never enter the counter.
  function automatic logic [BCD_WIDTH-1:0] bcd_saturate(input logic [BCD_WIDTH-1:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (value[7:4] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : value[7:4];
    units = (value[3:0] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : value[3:0];
    return {tens, units};
  endfunction

  function automatic logic [BCD_WIDTH-1:0] bcd_decrement(input logic [BCD_WIDTH-1:0] value);
    if (value[3:0] == 4'd0) begin
      return {value[7:4] - 4'd1, BCD_DIGIT_MAX};
    end
    return {value[7:4], value[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: pulses tick once every PRESCALE enabled cycles.
module tick_gen #(
  parameter int unsigned PRESCALE = 12500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [23:0] LAST = 24'(PRESCALE - 1);

  logic [23:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Clear wins over enable so a load or a fresh start always begins a full period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= 24'd0;
    end else if (clear) begin
      cnt <= 24'd0;
    end else if (enable) begin
      cnt <= tick ? 24'd0 : cnt + 24'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with load/start/pause control.
// Define COUNTDOWN_AUTORELOAD_EN to reload the last loaded value on reaching 00.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 12500000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOAD,
  input  logic [BCD_WIDTH-1:0] LOAD_VAL,
  input  logic                 START,
  input  logic                 PAUSE,
  output logic [BCD_WIDTH-1:0] COUNT,
  output logic                 BUSY,
  output logic                 DONE
);

  state_t               state_q;
  state_t               state_d;
  logic [BCD_WIDTH-1:0] count_q;
  logic [BCD_WIDTH-1:0] count_d;
  logic                 done_q;
  logic                 done_d;
  logic                 tick;
  logic                 clear;
  logic                 enable;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [BCD_WIDTH-1:0] reload_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reload_q <= '0;
    end else if (LOAD) begin
      reload_q <= bcd_saturate(LOAD_VAL);
    end
  end
`endif

  // The edge that sees PAUSE or LOAD must not advance the prescaler.
  assign enable = (state_q == RUN) && !PAUSE && !LOAD;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .CLK   (CLK),
    .RST   (RST),
    .clear (clear),
    .enable(enable),
    .tick  (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    if (LOAD) begin
      state_d = IDLE;
      count_d = bcd_saturate(LOAD_VAL);
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START && !PAUSE && (count_q != '0)) begin
            state_d = RUN;
            clear   = 1'b1;
          end
        end
        RUN: begin
          if (PAUSE) begin
            state_d = HOLD;
          end else if (tick) begin
            if (count_q == 8'h01) begin
              done_d  = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = IDLE;
`endif
            end else begin
              count_d = bcd_decrement(count_q);
            end
          end
        end
        HOLD: begin
          if (START && !PAUSE) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign COUNT = count_q;
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a decimal reference model.
// Honours COUNTDOWN_AUTORELOAD_EN in both the model and the directed scenarios.
module tb_countdown_timer;

  localparam int P = 4;

  logic       CLK;
  logic       RST;
  logic       LOAD;
  logic [7:0] LOAD_VAL;
  logic       START;
  logic       PAUSE;
  logic [7:0] COUNT;
  logic       BUSY;
  logic       DONE;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: plain decimal value and elapsed running cycles.
  int mValue;
  int mReload;
  int mPhase;
  bit mRun;
  bit mHold;
  bit mDone;

  countdown_timer #(
    .PRESCALE(P)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .START   (START),
    .PAUSE   (PAUSE),
    .COUNT   (COUNT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int digitClamp(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic logic [7:0] expCount();
    logic [7:0] r;
    r = 8'((mValue / 10) * 16 + (mValue % 10));
    return r;
  endfunction

  function automatic void modelReset();
    mValue  = 0;
    mReload = 0;
    mPhase  = 0;
    mRun    = 0;
    mHold   = 0;
    mDone   = 0;
  endfunction

  function automatic void modelStep(input bit load, input logic [7:0] val, input bit start, input bit pause);
    mDone = 0;
    if (load) begin
      mValue  = digitClamp(int'(val[7:4])) * 10 + digitClamp(int'(val[3:0]));
      mReload = mValue;
      mRun    = 0;
      mHold   = 0;
      mPhase  = 0;
    end else if (mRun) begin
      if (pause) begin
        mRun  = 0;
        mHold = 1;
      end else begin
        mPhase++;
        if (mPhase == P) begin
          mPhase = 0;
          mValue--;
          if (mValue == 0) begin
            mDone = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            mValue = mReload;
`else
            mRun = 0;
`endif
          end
        end
      end
    end else if (mHold) begin
      if (start && !pause) begin
        mHold = 0;
        mRun  = 1;
      end
    end else if (start && !pause && mValue != 0) begin
      mRun   = 1;
      mPhase = 0;
    end
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".count"}, COUNT, expCount());
    checkOutput({tag, ".busy"}, {7'd0, BUSY}, {7'd0, (mRun | mHold)});
    checkOutput({tag, ".done"}, {7'd0, DONE}, {7'd0, mDone});
  endtask

  // Called at a falling edge: drives inputs, advances one clock, checks against the model.
  task automatic applyStimulus(input bit load, input logic [7:0] val, input bit start, input bit pause);
    LOAD     = load;
    LOAD_VAL = val;
    START    = start;
    PAUSE    = pause;
    @(posedge CLK);
    modelStep(load, val, start, pause);
    @(negedge CLK);
    checkAll("cycle");
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic applyReset();
    RST = 1'b1;
    #1;
    modelReset();
    checkOutput("rst.count", COUNT, 8'h00);
    checkOutput("rst.busy", {7'd0, BUSY}, 8'h00);
    checkOutput("rst.done", {7'd0, DONE}, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    LOAD     = 1'b0;
    LOAD_VAL = 8'h00;
    START    = 1'b0;
    PAUSE    = 1'b0;
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    checkAll("reset");
    RST = 1'b0;

    // Start before any load is ignored because the count is 00.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("noload.busy", {7'd0, BUSY}, 8'h00);

    // Full countdown from 12 with a tens borrow.
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("s1.at4", COUNT, 8'h11);
    idleCycles(4);
    checkOutput("s1.at8", COUNT, 8'h10);
    idleCycles(4);
    checkOutput("s1.at12", COUNT, 8'h09);
    idleCycles(35);
    checkOutput("s1.at47.done", {7'd0, DONE}, 8'h00);
    idleCycles(1);
    checkOutput("s1.at48.count", COUNT, 8'h00);
    checkOutput("s1.at48.done", {7'd0, DONE}, 8'h01);
    idleCycles(1);
    checkOutput("s1.after.done", {7'd0, DONE}, 8'h00);
    checkOutput("s1.after.busy", {7'd0, BUSY}, 8'h00);

    // Load of 00 never runs and never signals done.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("s2.load.done", {7'd0, DONE}, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s2.busy", {7'd0, BUSY}, 8'h00);
    idleCycles(6);
    checkOutput("s2.done", {7'd0, DONE}, 8'h00);

    // Pause and resume keep the prescaler phase.
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("s3.hold.busy", {7'd0, BUSY}, 8'h01);
    checkOutput("s3.hold.count", COUNT, 8'h05);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("s3.res1", COUNT, 8'h05);
    idleCycles(1);
    checkOutput("s3.res2", COUNT, 8'h04);
    idleCycles(15);
    checkOutput("s3.pre.done", {7'd0, DONE}, 8'h00);
    idleCycles(1);
    checkOutput("s3.done", {7'd0, DONE}, 8'h01);
    checkOutput("s3.count", COUNT, 8'h00);

    // Saturating load, then START with PAUSE in idle is ignored.
    applyStimulus(1'b1, 8'h3F, 1'b0, 1'b0);
    checkOutput("s4.sat", COUNT, 8'h39);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("s4.busy", {7'd0, BUSY}, 8'h00);
    idleCycles(5);
    checkOutput("s4.count", COUNT, 8'h39);

    // Reset mid-run clears everything at once.
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("s5.busy.pre", {7'd0, BUSY}, 8'h01);
    applyReset();
    idleCycles(40);
    checkOutput("s5.done", {7'd0, DONE}, 8'h00);
    checkOutput("s5.count", COUNT, 8'h00);

`ifdef COUNTDOWN_AUTORELOAD_EN
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idleCycles(4);
      checkOutput("s6.mid", COUNT, 8'h01);
      idleCycles(4);
      checkOutput("s6.done", {7'd0, DONE}, 8'h01);
      checkOutput("s6.reload", COUNT, 8'h02);
      checkOutput("s6.busy", {7'd0, BUSY}, 8'h01);
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit         ld;
      bit         st;
      bit         ps;
      logic [7:0] v;
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        applyReset();
      end else begin
        applyStimulus(ld, v, st, ps);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 12500000, giving CLK cycles per decrement tick (legal range 2..2^24-1).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port LOAD, input, 1, which loads LOAD_VAL into the counter.
REQ-005 The block SHALL have port LOAD_VAL, input, 8, the start value as two BCD digits ([7:4] tens, [3:0] units).
REQ-006 The block SHALL have port START, input, 1, which starts or resumes the countdown.
REQ-007 The block SHALL have port PAUSE, input, 1, which freezes the countdown.
REQ-008 The block SHALL have port COUNT, output, 8, the current BCD value, registered.
REQ-009 The block SHALL have port BUSY, output, 1, high while in RUN or HOLD.
REQ-010 The block SHALL have port DONE, output, 1, a one-cycle pulse when the count reaches 00.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-012 LOAD SHALL, in any state, set COUNT to LOAD_VAL on the next edge, clear the prescaler, force IDLE and take priority over START and PAUSE.
REQ-013 A LOAD_VAL digit above 9 SHALL be saturated to 9 on load.
REQ-014 START in IDLE SHALL enter RUN with the prescaler cleared if COUNT is not 00; if COUNT is 00, START SHALL be ignored.
REQ-015 In RUN, the prescaler SHALL count 0..PRESCALE-1 and wrap; a tick SHALL occur on the edge where it equals PRESCALE-1.
REQ-016 Each tick SHALL decrement COUNT in BCD: units 0 becomes 9 with a borrow from tens; the first decrement occurs PRESCALE cycles after entering RUN.
REQ-017 A tick that takes COUNT from 01 to 00 SHALL assert DONE for exactly the cycle in which COUNT first reads 00, and the FSM SHALL return to IDLE.
REQ-018 PAUSE in RUN SHALL enter HOLD with the prescaler and COUNT frozen; START in HOLD SHALL resume RUN with the prescaler value retained.
REQ-019 START and PAUSE asserted together SHALL be resolved as PAUSE.
REQ-020 START while in RUN and PAUSE while in IDLE or HOLD SHALL have no effect.
REQ-021 DONE SHALL never assert other than by REQ-017; LOAD of 00 SHALL NOT produce DONE.

Reset
REQ-022 RST SHALL immediately force COUNT=8'h00, BUSY=0, DONE=0, prescaler=0, reload register=8'h00 and state IDLE, including mid-count.
REQ-023 After RST deasserts, the block SHALL wait in IDLE until LOAD.

Configuration
REQ-024 Macro COUNTDOWN_AUTORELOAD_EN SHALL control auto-reload.
- Defined: on the 01->00 tick, COUNT SHALL reload the last loaded (saturated) value, DONE SHALL still pulse for one cycle, and the state SHALL remain RUN.
- Not defined: behaviour SHALL be as REQ-017, and the reload register SHALL be absent.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef (IDLE/RUN/HOLD), the BCD digit-max constant (4'd9) and the BCD width constant (8).
REQ-026 The prescaler SHALL be a sub-module, tick_gen, with inputs CLK, RST, clear and enable, a parameter PRESCALE, and output tick.

Verification (sim PRESCALE=4)
REQ-027 The bench SHALL cover the following directed scenarios:
- LOAD 8'h12, START -> COUNT 11 at +4 cycles, 10 at +8, 09 at +12 (borrow); 00 with DONE=1 for one cycle at +48; then BUSY=0.
- LOAD 8'h00, START -> stays IDLE, BUSY=0, DONE never asserted.
- LOAD 8'h05, START, PAUSE after 2 cycles for 10 cycles, then START -> next decrement 2 cycles after resume; DONE at 20 running cycles total.
- LOAD 8'h3F -> COUNT=8'h39; START and PAUSE together in IDLE -> remains IDLE.
- RST pulse mid-RUN with COUNT 07 -> COUNT 00, BUSY 0 immediately; no DONE afterwards.
- With COUNTDOWN_AUTORELOAD_EN, LOAD 8'h02, START -> DONE pulses every 8 cycles, COUNT cycles 02,01,00->02, BUSY stays 1.
